pkt_spi_read: RTL and testbench

Reader-side counterpart of the SPI packet writer: drains a first-word-fall-through packet FIFO (fed by a future DSI/LP receive path or loopback) out through the SPI slave's simple-bus. Every SPI transaction addressed to `BASE` returns one status byte, then the packet bytes in order, then `8'h00` padding once the packet's last byte has been shifted out. It sits between the packet FIFO read port and the MISO byte source of the SPI slave core.

---
 rtl/pkt_spi_read.sv | 91 +++++++++
 tb/tb_pkt_spi_read.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pkt_spi_read.sv
// Packet FIFO readout for the SPI slave simple-bus: one status byte per transaction,
// then the packet bytes in order, then zero padding after the packet's last byte.
module pkt_spi_read #(
  parameter logic [7:0] BASE = 8'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sb_addr,
  input  logic [7:0] sb_data,
  input  logic       sb_first,
  input  logic       sb_last,
  input  logic       sb_stb,
  output logic [7:0] rd_data,
  input  logic [7:0] fifo_data,
  input  logic       fifo_last,
  input  logic       fifo_empty,
  output logic       fifo_rden,
  output logic       underrun
);

  typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_rd_data, w_rd_data_next;
  logic       r_underrun, w_underrun_next;
  logic       r_mid_packet, w_mid_packet_next;
  logic       w_sel;
  logic [7:0] w_status;
  logic       w_unused;

  // MOSI payload is irrelevant to a read-only window
  assign w_unused = ^sb_data;

  assign w_sel    = sb_stb && (sb_addr == BASE);
  assign w_status = {~fifo_empty, r_mid_packet, 5'b0, r_underrun};

  // IDLE shows the live status so it is valid straight out of reset or a transaction end
  assign rd_data  = (r_state == IDLE) ? w_status : r_rd_data;
  assign underrun = r_underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rd_data    <= 8'h00;
      r_underrun   <= 1'b0;
      r_mid_packet <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rd_data    <= w_rd_data_next;
      r_underrun   <= w_underrun_next;
      r_mid_packet <= w_mid_packet_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_rd_data_next    = r_rd_data;
    w_underrun_next   = r_underrun;
    w_mid_packet_next = r_mid_packet;
    fifo_rden         = 1'b0;

    if (r_state == IDLE) begin
      w_rd_data_next = w_status;
    end

    if (w_sel) begin
      // status byte has just gone out, so the reported underrun is acknowledged
      if (sb_first) begin
        w_underrun_next = 1'b0;
      end

      if (sb_last) begin
        w_state_next = IDLE;
      end else if (sb_first || (r_state == STREAM)) begin
        if (!fifo_empty) begin
          w_rd_data_next    = fifo_data;
          fifo_rden         = 1'b1;
          w_mid_packet_next = ~fifo_last;
          w_state_next      = fifo_last ? PAD : STREAM;
        end else begin
          w_rd_data_next  = 8'h00;
          w_underrun_next = 1'b1;
          w_state_next    = STREAM;
        end
      end else if (r_state == PAD) begin
        w_rd_data_next = 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_pkt_spi_read.sv
// Directed bench for pkt_spi_read: a small FWFT FIFO model feeds the DUT while
// SPI byte strobes are issued and each returned MISO byte is checked.
module tb_pkt_spi_read;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sb_addr;
  logic [7:0] sb_data;
  logic       sb_first;
  logic       sb_last;
  logic       sb_stb;
  logic [7:0] rd_data;
  logic [7:0] fifo_data;
  logic       fifo_last;
  logic       fifo_empty;
  logic       fifo_rden;
  logic       underrun;

  logic [8:0] mem [16];
  logic [4:0] head = '0;
  logic [4:0] tail = '0;
  int         pops = 0;
  int         checks = 0;
  int         passed = 0;
  int         pops_start;

  always #5 clk = ~clk;

  assign fifo_empty = (head == tail);
  assign fifo_data  = mem[head[3:0]][7:0];
  assign fifo_last  = mem[head[3:0]][8];

  always @(posedge clk) begin
    if (fifo_rden) begin
      head <= head + 5'd1;
      pops <= pops + 1;
    end
  end

  pkt_spi_read dut (
    .clk       (clk),
    .rst       (rst),
    .sb_addr   (sb_addr),
    .sb_data   (sb_data),
    .sb_first  (sb_first),
    .sb_last   (sb_last),
    .sb_stb    (sb_stb),
    .rd_data   (rd_data),
    .fifo_data (fifo_data),
    .fifo_last (fifo_last),
    .fifo_empty(fifo_empty),
    .fifo_rden (fifo_rden),
    .underrun  (underrun)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    for (int i = 0; i < 16; i++) begin
      if (i == int'(tail[3:0])) mem[i] = {last, d};
    end
    tail = tail + 5'd1;
    #1;
  endtask

  // One SPI data byte: rd_data is the byte going out in this slot, checked before the strobe edge.
  task automatic xfer(input string tag, input logic [7:0] addr, input logic first, input logic last,
                      input logic [7:0] exp_rd, input logic exp_pop);
    sb_addr  = addr;
    sb_first = first;
    sb_last  = last;
    sb_data  = 8'h5A;
    sb_stb   = 1'b1;
    #1;
    check({tag, " miso"}, rd_data, exp_rd);
    check({tag, " rden"}, {7'b0, fifo_rden}, {7'b0, exp_pop});
    @(posedge clk); #1;
    sb_stb   = 1'b0;
    sb_first = 1'b0;
    sb_last  = 1'b0;
    @(posedge clk); #1;
    $display("xfer %s addr=%02h first=%0b last=%0b miso=%02h", tag, addr, first, last, exp_rd);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 9'h000;
    rst = 1'b1; sb_addr = 8'h00; sb_data = 8'h00; sb_first = 1'b0; sb_last = 1'b0; sb_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset rd_data", rd_data, 8'h00);
    check("reset underrun", {7'b0, underrun}, 8'h00);
    check("reset rden", {7'b0, fifo_rden}, 8'h00);

    // Full 3-byte packet in a 5-byte read
    push(8'hA1, 1'b0); push(8'hA2, 1'b0); push(8'hA3, 1'b1);
    check("t1 status", rd_data, 8'h80);
    pops_start = pops;
    xfer("t1b0", 8'h30, 1, 0, 8'h80, 1);
    xfer("t1b1", 8'h30, 0, 0, 8'hA1, 1);
    xfer("t1b2", 8'h30, 0, 0, 8'hA2, 1);
    xfer("t1b3", 8'h30, 0, 0, 8'hA3, 0);
    xfer("t1b4", 8'h30, 0, 1, 8'h00, 0);
    check("t1 pops", 8'(pops - pops_start), 8'd3);
    check("t1 empty", {7'b0, fifo_empty}, 8'h01);
    check("t1 idle status", rd_data, 8'h00);

    // Packet split across a 2-byte and a 3-byte read
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b1);
    xfer("t2a0", 8'h30, 1, 0, 8'h80, 1);
    xfer("t2a1", 8'h30, 0, 1, 8'h11, 0);
    check("t2 mid status", rd_data, 8'hC0);
    xfer("t2b0", 8'h30, 1, 0, 8'hC0, 1);
    xfer("t2b1", 8'h30, 0, 0, 8'h22, 1);
    xfer("t2b2", 8'h30, 0, 1, 8'h33, 0);
    check("t2 end status", rd_data, 8'h00);

    // Read from an empty FIFO sets underrun; a single-byte read acknowledges it
    xfer("t3b0", 8'h30, 1, 0, 8'h00, 0);
    check("t3 underrun set", {7'b0, underrun}, 8'h01);
    xfer("t3b1", 8'h30, 0, 0, 8'h00, 0);
    xfer("t3b2", 8'h30, 0, 1, 8'h00, 0);
    check("t3 underrun held", {7'b0, underrun}, 8'h01);
    check("t3 status", rd_data, 8'h01);
    xfer("t3c0", 8'h30, 1, 1, 8'h01, 0);
    check("t3 underrun clr", {7'b0, underrun}, 8'h00);
    check("t3 status clr", rd_data, 8'h00);

    // Two packets queued: padding after the first, second left in the FIFO
    push(8'hB1, 1'b1); push(8'hC1, 1'b0); push(8'hC2, 1'b1);
    xfer("t4b0", 8'h30, 1, 0, 8'h80, 1);
    xfer("t4b1", 8'h30, 0, 0, 8'hB1, 0);
    xfer("t4b2", 8'h30, 0, 0, 8'h00, 0);
    xfer("t4b3", 8'h30, 0, 1, 8'h00, 0);
    check("t4 head", fifo_data, 8'hC1);
    check("t4 status", rd_data, 8'h80);

    // Foreign address: no pop, status keeps tracking
    xfer("t5b0", 8'h20, 1, 0, 8'h80, 0);
    xfer("t5b1", 8'h20, 0, 0, 8'h80, 0);
    xfer("t5b2", 8'h20, 0, 1, 8'h80, 0);
    check("t5 head", fifo_data, 8'hC1);

    // Reset in the middle of a packet transaction
    xfer("t6b0", 8'h30, 1, 0, 8'h80, 1);
    check("t6 streaming", rd_data, 8'hC1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6 rst status", rd_data, 8'h80);
    check("t6 rst underrun", {7'b0, underrun}, 8'h00);
    check("t6 rst rden", {7'b0, fifo_rden}, 8'h00);
    check("t6 head", fifo_data, 8'hC2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
